// File: rtl/mem_arb.sv
// mem_arb: shares one single-ported unified memory between fetch reads and data loads/stores.
// Latency: 0 added cycles; grant is combinational and responses route straight from the tag FIFO head.
// Backpressure: i_mem_ready low locks the current owner; a full tag FIFO holds reads but lets a pending store through.
//
// Build option MEM_ARB_RR_EN: round-robin arbitration. Without it, data has fixed priority
// over fetch, and fetch wins once after STARVE_LIM consecutive lost cycles.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), asynchronous active-high reset
//   i_if_req/i_if_addr           fetch read request; o_if_ready is the accept strobe
//   o_if_rvalid/o_if_rdata       fetch read response
//   i_dm_req/wen/addr/wdata/mask data load/store request; o_dm_ready is the accept strobe
//   o_dm_rvalid/o_dm_rdata       data load response
//   o_mem_* / i_mem_ready        memory request channel
//   i_mem_rvalid/i_mem_rdata     in-order read responses from memory
//   o_err                        sticky: a response arrived with no read outstanding
module mem_arb #(
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_ready,
   output logic        o_if_rvalid,
   output logic [31:0] o_if_rdata,
   input  logic        i_dm_req,
   input  logic        i_dm_wen,
   input  logic [31:0] i_dm_addr,
   input  logic [31:0] i_dm_wdata,
   input  logic [3:0]  i_dm_mask,
   output logic        o_dm_ready,
   output logic        o_dm_rvalid,
   output logic [31:0] o_dm_rdata,
   output logic        o_mem_req,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic        i_mem_ready,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_err
);

   localparam int   AW    = $clog2(DEPTH);
   localparam logic ID_IF = 1'b0;
   localparam logic ID_DM = 1'b1;

   logic          run;
   logic          prio_if;
   logic          pref_id;
   logic          want_vld;
   logic          want_rd;
   logic          gnt_vld;
   logic          gnt_id;
   logic          gnt_rd;
   logic          accept;
   logic          if_acc;
   logic          push;
   logic          pop;
   logic          lock_vld;
   logic          lock_id;
   logic          err_q;

   // Tag FIFO: one bit per outstanding read, 0 = fetch, 1 = data.
   logic          tag_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   tag_cnt;
   logic          fifo_full;
   logic          fifo_empty;
   logic          head_id;

   assign run        = ~i_rst;
   assign fifo_full  = (tag_cnt == (AW+1)'(DEPTH));
   assign fifo_empty = (tag_cnt == '0);
   assign head_id    = tag_mem[rd_ptr];

   // ------------------------------------------------------------------
   // Tie-break policy
   // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   // last_id holds the most recent winner; on a tie the other side goes next.
   logic last_id;

   assign prio_if = (last_id == ID_DM);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_id <= ID_IF;
      end else if (accept) begin
         last_id <= gnt_id;
      end
   end
`else
   localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   logic [SW-1:0] starve_cnt;

   assign prio_if = (starve_cnt == SW'(STARVE_LIM));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         starve_cnt <= '0;
      end else if (if_acc) begin
         starve_cnt <= '0;
      end else if (i_if_req && (starve_cnt != SW'(STARVE_LIM))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`endif

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   always_comb begin
      pref_id = ID_IF;
      if (lock_vld) begin
         pref_id = lock_id;
      end else if (i_if_req && i_dm_req) begin
         pref_id = prio_if ? ID_IF : ID_DM;
      end else if (i_dm_req) begin
         pref_id = ID_DM;
      end

      want_vld = (pref_id == ID_DM) ? i_dm_req : i_if_req;
      want_rd  = (pref_id == ID_IF) | ~i_dm_wen;

      gnt_vld = want_vld;
      gnt_id  = pref_id;
      // A read cannot issue with no tag slot. Only data can carry a store,
      // so the fallback exists only when fetch was the read winner.
      if (want_vld && want_rd && fifo_full) begin
         if ((pref_id == ID_IF) && i_dm_req && i_dm_wen) begin
            gnt_id = ID_DM;
         end else begin
            gnt_vld = 1'b0;
         end
      end
   end

   assign gnt_rd = (gnt_id == ID_IF) | ~i_dm_wen;
   assign accept = gnt_vld & i_mem_ready;
   assign if_acc = accept & (gnt_id == ID_IF);
   assign push   = accept & gnt_rd;
   assign pop    = i_mem_rvalid & ~fifo_empty;

   // ------------------------------------------------------------------
   // Lock, tag FIFO, error flag
   // ------------------------------------------------------------------
   // The lock simply mirrors "granted but not taken" from the previous
   // cycle, so it also releases if the owner ever drops its request.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lock_vld <= 1'b0;
         lock_id  <= ID_IF;
      end else begin
         lock_vld <= gnt_vld & ~i_mem_ready;
         if (gnt_vld) begin
            lock_id <= gnt_id;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
         tag_mem <= '{default: 1'b0};
      end else begin
         if (push) begin
            tag_mem[wr_ptr] <= gnt_id;
            wr_ptr          <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            tag_cnt <= tag_cnt + (AW+1)'(1);
         end else if (!push && pop) begin
            tag_cnt <= tag_cnt - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else if (i_mem_rvalid && fifo_empty) begin
         err_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs (all forced low while reset is held)
   // ------------------------------------------------------------------
   assign o_mem_req   = run & gnt_vld;
   assign o_mem_wen   = run & gnt_vld & (gnt_id == ID_DM) & i_dm_wen;
   assign o_mem_addr  = (run && gnt_vld) ? ((gnt_id == ID_DM) ? i_dm_addr : i_if_addr) : 32'h0;
   assign o_mem_wdata = (run && gnt_vld && (gnt_id == ID_DM)) ? i_dm_wdata : 32'h0;
   assign o_mem_mask  = (run && gnt_vld) ? ((gnt_id == ID_DM) ? i_dm_mask : 4'hF) : 4'h0;

   assign o_if_ready  = run & if_acc;
   assign o_dm_ready  = run & accept & (gnt_id == ID_DM);

   assign o_if_rvalid = run & pop & (head_id == ID_IF);
   assign o_dm_rvalid = run & pop & (head_id == ID_DM);
   assign o_if_rdata  = run ? i_mem_rdata : 32'h0;
   assign o_dm_rdata  = run ? i_mem_rdata : 32'h0;

   assign o_err       = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scenario bench for mem_arb; inputs change on the falling edge,
// outputs are sampled 2 time units later, state advances on the rising edge.
module tb_mem_arb;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_ready;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;
   logic        i_dm_req;
   logic        i_dm_wen;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic [3:0]  i_dm_mask;
   logic        o_dm_ready;
   logic        o_dm_rvalid;
   logic [31:0] o_dm_rdata;
   logic        o_mem_req;
   logic        o_mem_wen;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_mask;
   logic        i_mem_ready;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_err;

   int checks   = 0;
   int failures = 0;
   int resp_n   = 0;

   // Expected owner of each accepted read, 0 = fetch, 1 = data.
   bit exp_owner[$];

   mem_arb #(.DEPTH(4), .STARVE_LIM(3)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .o_if_ready  (o_if_ready),
      .o_if_rvalid (o_if_rvalid),
      .o_if_rdata  (o_if_rdata),
      .i_dm_req    (i_dm_req),
      .i_dm_wen    (i_dm_wen),
      .i_dm_addr   (i_dm_addr),
      .i_dm_wdata  (i_dm_wdata),
      .i_dm_mask   (i_dm_mask),
      .o_dm_ready  (o_dm_ready),
      .o_dm_rvalid (o_dm_rvalid),
      .o_dm_rdata  (o_dm_rdata),
      .o_mem_req   (o_mem_req),
      .o_mem_wen   (o_mem_wen),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_mask  (o_mem_mask),
      .i_mem_ready (i_mem_ready),
      .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata (i_mem_rdata),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic idle();
      i_if_req     = 1'b0;
      i_if_addr    = 32'h0;
      i_dm_req     = 1'b0;
      i_dm_wen     = 1'b0;
      i_dm_addr    = 32'h0;
      i_dm_wdata   = 32'h0;
      i_dm_mask    = 4'h0;
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0;
   endtask

   task automatic test_reset();
      logic [138:0] all_out;
      i_rst = 1'b1;
      idle();
      i_if_req     = 1'b1;
      i_if_addr    = 32'h40;
      i_mem_ready  = 1'b1;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h1234;
      #2;
      all_out = {o_if_ready, o_if_rvalid, o_if_rdata, o_dm_ready, o_dm_rvalid, o_dm_rdata,
                 o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask, o_err};
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", all_out);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      idle();
      #2;
      checks++;
      if ({o_err, o_mem_req, o_if_ready, o_dm_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release got=%b exp=0000", {o_err, o_mem_req, o_if_ready, o_dm_ready});
      end
   endtask

`ifndef MEM_ARB_RR_EN
   // Data load and fetch both request; fetch loses cycles 0..2 and wins cycle 3.
   task automatic test_priority();
      logic [38:0] exp;
      logic [38:0] got;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = 1'b1;
         i_dm_req    = 1'b1;
         i_dm_wen    = 1'b0;
         i_dm_addr   = 32'h100;
         i_dm_mask   = 4'hF;
         i_if_req    = 1'b1;
         i_if_addr   = 32'h40;
         #2;
         // {if_ready, dm_ready, wen, mask, addr}
         exp = (c < 3) ? {1'b0, 1'b1, 1'b0, 4'hF, 32'h100} : {1'b1, 1'b0, 1'b0, 4'hF, 32'h40};
         got = {o_if_ready, o_dm_ready, o_mem_wen, o_mem_mask, o_mem_addr};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL prio_cycle%0d got=%h exp=%h", c, got, exp);
         end
         exp_owner.push_back(c < 3);
      end
   endtask

   // Continues from test_priority with four reads outstanding.
   task automatic test_full_fifo();
      logic [34:0] exp;
      logic [34:0] got;
      bit          owner;
      logic [31:0] rd;
      for (int c = 4; c < 10; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = 1'b1;
         i_if_req    = 1'b1;
         i_if_addr   = 32'h70;
         if (c == 7) begin
            i_dm_req   = 1'b1;
            i_dm_wen   = 1'b1;
            i_dm_addr  = 32'h300;
            i_dm_wdata = 32'h5A5A_0300;
            i_dm_mask  = 4'h3;
         end
         if (c == 8) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = 32'hF0;
         end
         #2;
         // {if_ready, dm_ready, mem_req, addr}
         case (c)
            7:       exp = {1'b0, 1'b1, 1'b1, 32'h300};
            9:       exp = {1'b1, 1'b0, 1'b1, 32'h70};
            default: exp = {1'b0, 1'b0, 1'b0, 32'h0};
         endcase
         got = {o_if_ready, o_dm_ready, o_mem_req, o_mem_addr};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL full_cycle%0d got=%h exp=%h", c, got, exp);
         end
         if (c == 7) begin
            checks++;
            if ({o_mem_wen, o_mem_mask, o_mem_wdata} !== {1'b1, 4'h3, 32'h5A5A_0300}) begin
               failures++;
               $display("FAIL full_store_payload got=%h exp=%h",
                        {o_mem_wen, o_mem_mask, o_mem_wdata}, {1'b1, 4'h3, 32'h5A5A_0300});
            end
         end
         if (c == 8) begin
            owner = exp_owner.pop_front();
            checks++;
            if ({o_if_rvalid, o_dm_rvalid, o_dm_rdata} !== {~owner, owner, 32'hF0}) begin
               failures++;
               $display("FAIL full_first_resp got=%b%b %h exp=%b%b %h",
                        o_if_rvalid, o_dm_rvalid, o_dm_rdata, ~owner, owner, 32'hF0);
            end
         end
         if (c == 9) exp_owner.push_back(1'b0);
      end
      while (exp_owner.size() > 0) begin
         owner = exp_owner.pop_front();
         rd    = 32'hC000_0000 + 32'(resp_n);
         resp_n++;
         @(negedge i_clk);
         idle();
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = rd;
         #2;
         checks++;
         if ({o_if_rvalid, o_dm_rvalid} !== {~owner, owner} ||
             (owner ? o_dm_rdata : o_if_rdata) !== rd) begin
            failures++;
            $display("FAIL full_drain got=%b%b if=%h dm=%h exp owner=%0d data=%h",
                     o_if_rvalid, o_dm_rvalid, o_if_rdata, o_dm_rdata, owner, rd);
         end
      end
   endtask
`endif

   task automatic test_lock();
      logic [33:0] exp;
      logic [33:0] got;
      bit          owner;
      logic [31:0] rd;
      // Store stalled by memory; fetch arrives during the stall.
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = (c >= 2);
         if (c < 3) begin
            i_dm_req   = 1'b1;
            i_dm_wen   = 1'b1;
            i_dm_addr  = 32'h200;
            i_dm_wdata = 32'hDEAD_0200;
            i_dm_mask  = 4'hF;
         end
         if (c >= 1) begin
            i_if_req  = 1'b1;
            i_if_addr = 32'h44;
         end
         #2;
         // {if_ready, dm_ready, addr}
         case (c)
            2:       exp = {1'b0, 1'b1, 32'h200};
            3:       exp = {1'b1, 1'b0, 32'h44};
            default: exp = {1'b0, 1'b0, 32'h200};
         endcase
         got = {o_if_ready, o_dm_ready, o_mem_addr};
         checks++;
         if (got !== exp || o_mem_req !== 1'b1) begin
            failures++;
            $display("FAIL lock_store_cycle%0d got=%h req=%b exp=%h req=1", c, got, o_mem_req, exp);
         end
      end
      exp_owner.push_back(1'b0);
      // Fetch stalled by memory; a data load arrives and must not steal the port.
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = (c >= 2);
         if (c < 3) begin
            i_if_req  = 1'b1;
            i_if_addr = 32'h48;
         end
         if (c >= 1) begin
            i_dm_req  = 1'b1;
            i_dm_addr = 32'h104;
            i_dm_mask = 4'hF;
         end
         #2;
         case (c)
            2:       exp = {1'b1, 1'b0, 32'h48};
            3:       exp = {1'b0, 1'b1, 32'h104};
            default: exp = {1'b0, 1'b0, 32'h48};
         endcase
         got = {o_if_ready, o_dm_ready, o_mem_addr};
         checks++;
         if (got !== exp || o_mem_req !== 1'b1) begin
            failures++;
            $display("FAIL lock_fetch_cycle%0d got=%h req=%b exp=%h req=1", c, got, o_mem_req, exp);
         end
      end
      exp_owner.push_back(1'b0);
      exp_owner.push_back(1'b1);
      while (exp_owner.size() > 0) begin
         owner = exp_owner.pop_front();
         rd    = 32'hD000_0000 + 32'(resp_n);
         resp_n++;
         @(negedge i_clk);
         idle();
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = rd;
         #2;
         checks++;
         if ({o_if_rvalid, o_dm_rvalid} !== {~owner, owner} ||
             (owner ? o_dm_rdata : o_if_rdata) !== rd) begin
            failures++;
            $display("FAIL lock_drain got=%b%b if=%h dm=%h exp owner=%0d data=%h",
                     o_if_rvalid, o_dm_rvalid, o_if_rdata, o_dm_rdata, owner, rd);
         end
      end
   endtask

   task automatic test_routing();
      logic [31:0] addr_tab [4];
      logic [31:0] data_tab [4];
      bit          owner;
      addr_tab = '{32'h50, 32'h60, 32'h54, 32'h64};
      data_tab = '{32'hA, 32'hB, 32'hC, 32'hD};
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = 1'b1;
         if (c % 2 == 0) begin
            i_if_req  = 1'b1;
            i_if_addr = addr_tab[c];
         end else begin
            i_dm_req  = 1'b1;
            i_dm_addr = addr_tab[c];
            i_dm_mask = 4'hF;
         end
         #2;
         checks++;
         if ({o_if_ready, o_dm_ready, o_mem_addr} !== {(c % 2 == 0), (c % 2 == 1), addr_tab[c]}) begin
            failures++;
            $display("FAIL route_accept%0d got=%b%b %h exp=%b%b %h", c, o_if_ready, o_dm_ready,
                     o_mem_addr, (c % 2 == 0), (c % 2 == 1), addr_tab[c]);
         end
         exp_owner.push_back(c % 2 == 1);
      end
      for (int c = 0; c < 4; c++) begin
         owner = exp_owner.pop_front();
         @(negedge i_clk);
         idle();
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = data_tab[c];
         #2;
         checks++;
         if ({o_if_rvalid, o_dm_rvalid} !== {~owner, owner} ||
             (owner ? o_dm_rdata : o_if_rdata) !== data_tab[c]) begin
            failures++;
            $display("FAIL route_resp%0d got=%b%b if=%h dm=%h exp owner=%0d data=%h", c,
                     o_if_rvalid, o_dm_rvalid, o_if_rdata, o_dm_rdata, owner, data_tab[c]);
         end
      end
   endtask

   // A read accept and a response in the same cycle.
   task automatic test_push_pop();
      @(negedge i_clk);
      idle();
      i_mem_ready = 1'b1;
      i_if_req    = 1'b1;
      i_if_addr   = 32'h58;
      #2;
      checks++;
      if (o_if_ready !== 1'b1) begin
         failures++;
         $display("FAIL pp_fetch_accept got=%b exp=1", o_if_ready);
      end
      @(negedge i_clk);
      idle();
      i_mem_ready  = 1'b1;
      i_dm_req     = 1'b1;
      i_dm_addr    = 32'h68;
      i_dm_mask    = 4'hF;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h11;
      #2;
      checks++;
      if ({o_dm_ready, o_if_rvalid, o_dm_rvalid, o_if_rdata} !== {3'b110, 32'h11}) begin
         failures++;
         $display("FAIL pp_same_cycle got=%b%b%b %h exp=110 %h",
                  o_dm_ready, o_if_rvalid, o_dm_rvalid, o_if_rdata, 32'h11);
      end
      @(negedge i_clk);
      idle();
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h22;
      #2;
      checks++;
      if ({o_if_rvalid, o_dm_rvalid, o_dm_rdata} !== {2'b01, 32'h22}) begin
         failures++;
         $display("FAIL pp_second_resp got=%b%b %h exp=01 %h", o_if_rvalid, o_dm_rvalid, o_dm_rdata, 32'h22);
      end
      @(negedge i_clk);
      idle();
      #2;
      checks++;
      if (o_err !== 1'b0) begin
         failures++;
         $display("FAIL pp_no_err got=%b exp=0", o_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [138:0] all_out;
      for (int c = 0; c < 2; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = 1'b1;
         i_if_req    = 1'b1;
         i_if_addr   = 32'h80 + 32'(4 * c);
         #2;
         checks++;
         if (o_if_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_accept%0d got=%b exp=1", c, o_if_ready);
         end
      end
      @(negedge i_clk);
      i_rst        = 1'b1;
      i_dm_req     = 1'b1;
      i_dm_wen     = 1'b1;
      i_dm_addr    = 32'h310;
      i_dm_wdata   = 32'h77;
      i_dm_mask    = 4'hF;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h66;
      #2;
      all_out = {o_if_ready, o_if_rvalid, o_if_rdata, o_dm_ready, o_dm_rvalid, o_dm_rdata,
                 o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask, o_err};
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL rmid_outputs got=%h exp=0", all_out);
      end
      exp_owner.delete();
      @(negedge i_clk);
      i_rst = 1'b0;
      idle();
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h99;
      #2;
      checks++;
      if ({o_if_rvalid, o_dm_rvalid, o_err} !== 3'b000) begin
         failures++;
         $display("FAIL rmid_stale_resp got=%b exp=000", {o_if_rvalid, o_dm_rvalid, o_err});
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge i_clk);
         idle();
         #2;
         checks++;
         if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL rmid_err_sticky%0d got=%b exp=1", c, o_err);
         end
      end
      @(negedge i_clk);
      i_rst = 1'b1;
      #2;
      checks++;
      if (o_err !== 1'b0) begin
         failures++;
         $display("FAIL rmid_err_async_clear got=%b exp=0", o_err);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

`ifdef MEM_ARB_RR_EN
   // Both sides requesting every cycle; the grant alternates starting with data.
   task automatic test_rr();
      bit          owner;
      logic [31:0] rd;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         idle();
         i_mem_ready = 1'b1;
         i_dm_req    = 1'b1;
         i_dm_wen    = 1'b1;
         i_dm_addr   = 32'h400;
         i_dm_wdata  = 32'h44;
         i_dm_mask   = 4'hF;
         i_if_req    = 1'b1;
         i_if_addr   = 32'h90;
         #2;
         checks++;
         if ({o_dm_ready, o_if_ready} !== {(c % 2 == 0), (c % 2 == 1)}) begin
            failures++;
            $display("FAIL rr_cycle%0d got=%b%b exp=%b%b", c, o_dm_ready, o_if_ready,
                     (c % 2 == 0), (c % 2 == 1));
         end
         if (c % 2 == 1) exp_owner.push_back(1'b0);
      end
      while (exp_owner.size() > 0) begin
         owner = exp_owner.pop_front();
         rd    = 32'hE000_0000 + 32'(resp_n);
         resp_n++;
         @(negedge i_clk);
         idle();
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = rd;
         #2;
         checks++;
         if ({o_if_rvalid, o_dm_rvalid} !== {~owner, owner} ||
             (owner ? o_dm_rdata : o_if_rdata) !== rd) begin
            failures++;
            $display("FAIL rr_drain got=%b%b if=%h dm=%h exp owner=%0d data=%h",
                     o_if_rvalid, o_dm_rvalid, o_if_rdata, o_dm_rdata, owner, rd);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifndef MEM_ARB_RR_EN
      test_priority();
      test_full_fifo();
`endif
      test_lock();
      test_routing();
      test_push_pop();
      test_reset_mid();
`ifdef MEM_ARB_RR_EN
      test_rr();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
